instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the RV32I core. Owns the program counter and issues word requests to instruction memory over a valid/ready request channel. Accepts responses over a valid-only response channel.
- Presents each fetched instruction, with its PC, to the decode stage (opcode decode and immediate sign extension) over a valid/ready handshake.
- Supports redirects from branch/jump resolution and squashes any wrong-path fetch still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 00.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  request to instruction memory is valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  byte address of the requested word; always equals the current PC.
- imem_rsp_valid  in  1  response data valid this cycle; memory has no backpressure.
- imem_rsp_data  in  32  fetched instruction word.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 00.
- instr_valid  out  1  instr_out and instr_pc are valid for decode.
- instr_ready  in  1  decode accepts the instruction.
- instr_out  out  32  registered instruction word.
- instr_pc  out  32  byte address of instr_out.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= REQ, pc <= RESET_PC, squash <= 0, instr_valid <= 0.
  - instr_out <= 32'h0000_0013 (NOP), instr_pc <= RESET_PC.
  - imem_req_valid is 0 while rst is high.
  - Reset mid-operation discards everything, including an outstanding request. Instruction memory shares rst, so no stale response arrives after reset.
- At most one memory request is outstanding. FSM states: REQ, WAIT, HOLD.
- REQ:
  - imem_req_valid = ~redirect_valid; imem_req_addr = pc.
  - Handshake (valid & ready): go to WAIT.
  - redirect_valid: pc <= {redirect_pc[31:2],2'b00}; stay in REQ; no request is issued that cycle.
- WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid with squash=0 and no redirect:
    - instr_out <= imem_rsp_data; instr_pc <= pc; instr_valid <= 1.
    - pc <= pc + PC_STEP (32-bit wrap: 32'hFFFF_FFFC + 4 = 0).
    - Go to HOLD.
  - On imem_rsp_valid with squash=1: drop the data; squash <= 0; go to REQ.
  - redirect_valid with no response this cycle: pc <= redirect target; squash <= 1; stay in WAIT.
  - redirect_valid and imem_rsp_valid in the same cycle: drop the response; pc <= redirect target; squash <= 0; go to REQ.
- HOLD:
  - instr_valid = 1. instr_out and instr_pc are stable until the handshake completes.
  - instr_valid & instr_ready: instr_valid <= 0; go to REQ.
  - redirect_valid with no handshake: discard the held instruction (instr_valid <= 0); pc <= redirect target; go to REQ.
  - redirect_valid and handshake in the same cycle: the handshake completes (decode owns that instruction); pc <= redirect target; go to REQ.
- imem_rsp_valid outside WAIT is ignored.
- instr_valid never drops without a handshake, except on redirect or reset.
- Latency:
  - Minimum 3 cycles per instruction with zero-wait memory (REQ, WAIT, HOLD).
  - Redirect to first request issued: 1 cycle from REQ/HOLD. From WAIT, the request is issued only after the squashed response drains.

Test Plan:
- Reset then free run, imem_req_ready=1, response 1 cycle after accept, instr_ready=1 -> requests at 0x0, 0x4, 0x8; instr_pc 0x0/0x4/0x8 with matching instr_out; one instruction every 3 cycles.
- instr_ready held 0 for 5 cycles in HOLD with word 0x00500093 at PC 0x4 -> instr_valid stays 1; instr_out and instr_pc stay stable; no new imem request until instr_ready=1.
- Redirect to 0x100 while in WAIT, response (0xDEADBEEF) 2 cycles later -> 0xDEADBEEF never appears on instr_out; next request addr 0x100.
- Redirect to 0x203 in the same cycle as imem_rsp_valid -> response dropped; next request addr 0x200 (low bits forced).
- Redirect to 0x40 in HOLD with instr_ready=1 in the same cycle -> held instruction counted as consumed once; next request addr 0x40.
- PC at 0xFFFFFFFC, response accepted -> next request addr 0x00000000. Then rst asserted while in WAIT -> next cycle state REQ, pc=RESET_PC, instr_valid=0, instr_out=0x00000013.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Interface bundling the fetch unit's instruction-memory channel, the redirect
// input and the decode-side instruction channel.
//   master : the fetch unit (drives requests and instructions out)
//   slave  : the environment (memory, branch resolution, decode)
// Signals:
//   imem_req_valid/ready/addr : word request to instruction memory
//   imem_rsp_valid/data       : valid-only response from instruction memory
//   redirect_valid/pc         : one-cycle restart of fetch at a new PC
//   instr_valid/ready/out/pc  : fetched instruction handed to decode
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr_out, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr_out, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage. Owns the PC, issues one word request at a time to
// instruction memory, registers the returned word with its PC and holds it
// for decode until accepted. Redirects restart fetch at a word-aligned target
// and squash any wrong-path response still in flight.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : instr_fetch_unit_if.master (memory, redirect and decode channels)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic        squash, squash_d;
  logic        valid, valid_d;
  logic [31:0] instr, instr_d;
  logic [31:0] ipc, ipc_d;

  logic [31:0] redirect_target;
  logic        handshake;

  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
  assign handshake       = valid & bus.instr_ready;

  // A redirect in REQ takes priority over issuing the stale-path request.
  assign bus.imem_req_valid = (state == REQ) & ~bus.redirect_valid & ~rst;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = valid;
  assign bus.instr_out      = instr;
  assign bus.instr_pc       = ipc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= REQ;
      pc     <= RESET_PC;
      squash <= 1'b0;
      valid  <= 1'b0;
      instr  <= NOP;
      ipc    <= RESET_PC;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      squash <= squash_d;
      valid  <= valid_d;
      instr  <= instr_d;
      ipc    <= ipc_d;
    end
  end

  always_comb begin
    state_d  = state;
    pc_d     = pc;
    squash_d = squash;
    valid_d  = valid;
    instr_d  = instr;
    ipc_d    = ipc;

    unique case (state)
      REQ: begin
        if (bus.redirect_valid) begin
          pc_d = redirect_target;
        end else if (bus.imem_req_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (bus.imem_rsp_valid) begin
          // Both a squashed response and one colliding with a redirect are
          // dropped; the PC already (or now) points at the new target.
          if (bus.redirect_valid) begin
            pc_d     = redirect_target;
            squash_d = 1'b0;
            state_d  = REQ;
          end else if (squash) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            instr_d = bus.imem_rsp_data;
            ipc_d   = pc;
            valid_d = 1'b1;
            pc_d    = pc + 32'(PC_STEP);
            state_d = HOLD;
          end
        end else if (bus.redirect_valid) begin
          // Request still outstanding: remember to discard its response.
          pc_d     = redirect_target;
          squash_d = 1'b1;
        end
      end

      HOLD: begin
        // With or without a handshake, a redirect empties the slot; if the
        // handshake coincides, decode has already taken the instruction.
        if (handshake || bus.redirect_valid) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
        if (bus.redirect_valid) begin
          pc_d = redirect_target;
        end
      end

      default: begin
        state_d = REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios for reset,
// free-running fetch, decode stall, redirects and PC wrap, followed by a
// randomized run checked against an architectural model of the expected
// instruction stream (next PC to deliver, redirect targets, memory contents).
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic idle_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); idle_inputs(); rst = 1'b1; bus.imem_req_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid_in_rst: got %0b want 0", bus.imem_req_valid); end
    @(negedge clk); #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid_in_rst2: got %0b want 0", bus.imem_req_valid); end
    @(negedge clk); rst = 1'b0; bus.imem_req_ready = 1'b0; #1;
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid: got %0b want 0", bus.instr_valid); end
    n_cmp++; if (bus.instr_out !== NOP) begin n_err++; $display("FAIL reset_instr_out: got %h want %h", bus.instr_out, NOP); end
    n_cmp++; if (bus.instr_pc !== RESET_PC) begin n_err++; $display("FAIL reset_instr_pc: got %h want %h", bus.instr_pc, RESET_PC); end
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin n_err++; $display("FAIL reset_first_req: got v=%0b a=%h want v=1 a=%h", bus.imem_req_valid, bus.imem_req_addr, RESET_PC); end
  endtask

  task automatic test_free_run();
    logic [31:0] req_q[$];
    logic [31:0] hs_pc[$];
    logic [31:0] hs_dat[$];
    int          hs_cyc[$];
    bit          pend = 0;
    logic [31:0] paddr = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      idle_inputs();
      bus.imem_rsp_valid = pend;
      bus.imem_rsp_data  = mem_word(paddr);
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      #1;
      if (bus.imem_rsp_valid) pend = 0;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        req_q.push_back(bus.imem_req_addr);
        pend  = 1;
        paddr = bus.imem_req_addr;
      end
      if (bus.instr_valid && bus.instr_ready) begin
        hs_pc.push_back(bus.instr_pc);
        hs_dat.push_back(bus.instr_out);
        hs_cyc.push_back(c);
      end
    end
    n_cmp++; if (req_q.size() != 3 || hs_pc.size() != 3) begin n_err++; $display("FAIL free_run_counts: got req=%0d instr=%0d want 3/3", req_q.size(), hs_pc.size()); end
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_a;
      exp_a = RESET_PC + 32'(4 * k);
      n_cmp++; if (k >= req_q.size() || req_q[k] !== exp_a) begin n_err++; $display("FAIL free_run_req_addr[%0d]: got %h want %h", k, (k < req_q.size()) ? req_q[k] : 32'hx, exp_a); end
      n_cmp++; if (k >= hs_pc.size() || hs_pc[k] !== exp_a || hs_dat[k] !== mem_word(exp_a)) begin n_err++; $display("FAIL free_run_instr[%0d]: got pc=%h d=%h want pc=%h d=%h", k, (k < hs_pc.size()) ? hs_pc[k] : 32'hx, (k < hs_dat.size()) ? hs_dat[k] : 32'hx, exp_a, mem_word(exp_a)); end
      n_cmp++; if (k >= hs_cyc.size() || hs_cyc[k] != 2 + 3 * k) begin n_err++; $display("FAIL free_run_timing[%0d]: got cycle %0d want %0d", k, (k < hs_cyc.size()) ? hs_cyc[k] : -1, 2 + 3 * k); end
    end
  endtask

  task automatic test_hold_stall();
    @(negedge clk); idle_inputs(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h4; bus.imem_req_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_req_during_redirect: got %0b want 0", bus.imem_req_valid); end
    @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h4) begin n_err++; $display("FAIL stall_req_addr: got v=%0b a=%h want v=1 a=00000004", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0050_0093; #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 32'h0050_0093 || bus.instr_pc !== 32'h4 || bus.imem_req_valid !== 1'b0) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v=%0b d=%h pc=%h req=%0b want v=1 d=00500093 pc=00000004 req=0", c, bus.instr_valid, bus.instr_out, bus.instr_pc, bus.imem_req_valid);
      end
    end
    @(negedge clk); idle_inputs(); bus.instr_ready = 1'b1; #1;
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_release_valid: got %0b want 1", bus.instr_valid); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8) begin n_err++; $display("FAIL stall_next_req: got v=%0b req=%0b a=%h want v=0 req=1 a=00000008", bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    bit seen_bad = 0;
    @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8) begin n_err++; $display("FAIL rdw_req: got v=%0b a=%h want v=1 a=00000008", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); idle_inputs(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; #1;
    @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rdw_no_req_before_drain: got %0b want 0", bus.imem_req_valid); end
    @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF; #1;
    @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
    if (bus.instr_out === 32'hDEAD_BEEF) seen_bad = 1;
    n_cmp++; if (bus.instr_valid !== 1'b0 || seen_bad) begin n_err++; $display("FAIL rdw_squashed: got v=%0b d=%h want v=0 and d!=deadbeef", bus.instr_valid, bus.instr_out); end
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin n_err++; $display("FAIL rdw_next_req: got v=%0b a=%h want v=1 a=00000100", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = mem_word(32'h100); #1;
    @(negedge clk); idle_inputs(); bus.instr_ready = 1'b1; #1;
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 || bus.instr_out !== mem_word(32'h100)) begin n_err++; $display("FAIL rdw_target_instr: got v=%0b pc=%h d=%h want v=1 pc=00000100 d=%h", bus.instr_valid, bus.instr_pc, bus.instr_out, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_same_rsp();
    @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h104) begin n_err++; $display("FAIL rds_req: got v=%0b a=%h want v=1 a=00000104", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hCAFE_F00D; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203; #1;
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rds_dropped: got v=%0b want 0", bus.instr_valid); end
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin n_err++; $display("FAIL rds_next_req: got v=%0b a=%h want v=1 a=00000200", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_redirect_hold();
    int consumed = 0;
    @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin n_err++; $display("FAIL rdh_req: got v=%0b a=%h want v=1 a=00000200", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = mem_word(32'h200); #1;
    @(negedge clk); idle_inputs(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; bus.instr_ready = 1'b1; #1;
    if (bus.instr_valid === 1'b1) consumed++;
    n_cmp++; if (bus.instr_pc !== 32'h200 || bus.instr_out !== mem_word(32'h200)) begin n_err++; $display("FAIL rdh_held: got pc=%h d=%h want pc=00000200 d=%h", bus.instr_pc, bus.instr_out, mem_word(32'h200)); end
    @(negedge clk); idle_inputs(); bus.instr_ready = 1'b1; #1;
    if (bus.instr_valid === 1'b1) consumed++;
    n_cmp++; if (consumed != 1) begin n_err++; $display("FAIL rdh_consumed_once: got %0d want 1", consumed); end
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h40) begin n_err++; $display("FAIL rdh_next_req: got v=%0b a=%h want v=1 a=00000040", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_wrap_reset();
    @(negedge clk); idle_inputs(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF; #1;
    @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req_top: got v=%0b a=%h want v=1 a=fffffffc", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = mem_word(32'hFFFF_FFFC); #1;
    @(negedge clk); idle_inputs(); bus.instr_ready = 1'b1; #1;
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hFFFF_FFFC || bus.instr_out !== mem_word(32'hFFFF_FFFC)) begin n_err++; $display("FAIL wrap_instr_top: got v=%0b pc=%h d=%h want v=1 pc=fffffffc d=%h", bus.instr_valid, bus.instr_pc, bus.instr_out, mem_word(32'hFFFF_FFFC)); end
    @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin n_err++; $display("FAIL wrap_req_zero: got v=%0b a=%h want v=1 a=00000000", bus.imem_req_valid, bus.imem_req_addr); end
    // Now in WAIT with a request outstanding; reset discards it.
    @(negedge clk); idle_inputs(); rst = 1'b1; bus.imem_req_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL wrap_rst_req_valid: got %0b want 0", bus.imem_req_valid); end
    @(negedge clk); idle_inputs(); rst = 1'b0; #1;
    n_cmp++; if (bus.instr_valid !== 1'b0 || bus.instr_out !== NOP || bus.instr_pc !== RESET_PC) begin n_err++; $display("FAIL wrap_rst_outputs: got v=%0b d=%h pc=%h want v=0 d=%h pc=%h", bus.instr_valid, bus.instr_out, bus.instr_pc, NOP, RESET_PC); end
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin n_err++; $display("FAIL wrap_rst_req: got v=%0b a=%h want v=1 a=%h", bus.imem_req_valid, bus.imem_req_addr, RESET_PC); end
    // A response arriving in REQ must be ignored.
    @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0BAD_0BAD; #1;
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin n_err++; $display("FAIL rsp_ignored_in_req: got v=%0b req=%0b a=%h want v=0 req=1 a=%h", bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr, RESET_PC); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = RESET_PC;
    bit          pending = 0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    bit          prev_v = 0, prev_hs = 0, prev_rd = 0;
    logic [31:0] prev_out = '0, prev_pc = '0;
    int          delivered = 0;
    bit          hs;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.imem_rsp_valid = pending ? (cnt == 0) : ($urandom_range(0, 15) == 0);
      bus.imem_rsp_data  = pending ? mem_word(paddr) : $urandom;
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.instr_ready    = ($urandom_range(0, 2) != 0);
      bus.redirect_valid = ($urandom_range(0, 11) == 0);
      bus.redirect_pc    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1023));
      #1;
      if (prev_v && !prev_hs && !prev_rd) begin
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== prev_out || bus.instr_pc !== prev_pc) begin
          n_err++; $display("FAIL rand_hold_stable @%0d: got v=%0b d=%h pc=%h want v=1 d=%h pc=%h", i, bus.instr_valid, bus.instr_out, bus.instr_pc, prev_out, prev_pc);
        end
      end
      if (bus.redirect_valid) begin
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rand_req_on_redirect @%0d: got %0b want 0", i, bus.imem_req_valid); end
      end
      if (pending) begin
        if (bus.imem_rsp_valid) pending = 0;
        else cnt--;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        n_cmp++; if (pending || bus.imem_req_addr !== exp_pc) begin
          n_err++; $display("FAIL rand_req @%0d: got a=%h outstanding=%0b want a=%h outstanding=0", i, bus.imem_req_addr, pending, exp_pc);
        end
        pending = 1;
        paddr   = bus.imem_req_addr;
        cnt     = $urandom_range(0, 2);
      end
      hs = bus.instr_valid && bus.instr_ready;
      if (hs) begin
        n_cmp++; if (bus.instr_pc !== exp_pc || bus.instr_out !== mem_word(exp_pc)) begin
          n_err++; $display("FAIL rand_instr @%0d: got pc=%h d=%h want pc=%h d=%h", i, bus.instr_pc, bus.instr_out, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (bus.redirect_valid) exp_pc = {bus.redirect_pc[31:2], 2'b00};
      prev_v   = bus.instr_valid;
      prev_hs  = hs;
      prev_rd  = bus.redirect_valid;
      prev_out = bus.instr_out;
      prev_pc  = bus.instr_pc;
    end
    n_cmp++; if (delivered < 100) begin n_err++; $display("FAIL rand_progress: got %0d instructions want >= 100", delivered); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_free_run();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_same_rsp();
    test_redirect_hold();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
